// File: rtl/rv32v_pipe_ctrl.sv
// rv32v_pipe_ctrl: hazard and pipeline-control unit for the rv32v vector pipeline.
// Produces per-stage stall/flush vectors for N_STAGES stages. A vector-register
// scoreboard blocks decode on RAW/WAW hazards. Redirects (CSR write or exception)
// start a flush hold, followed by a drain of the commit stage.
// Optional macro RV32V_PIPE_CTRL_PERF_EN adds saturating performance counters.
module rv32v_pipe_ctrl #(
  parameter int N_STAGES   = 5,
  parameter int DEC_IDX    = 2,
  parameter int NUM_VREGS  = 32,
  parameter int FLUSH_HOLD = 2
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic [N_STAGES-1:0]           busy,
  input  logic                          csr_update,
  input  logic                          exception,
  input  logic                          dec_valid,
  input  logic [$clog2(NUM_VREGS)-1:0]  dec_vs1,
  input  logic [$clog2(NUM_VREGS)-1:0]  dec_vs2,
  input  logic [$clog2(NUM_VREGS)-1:0]  dec_vd,
  input  logic                          dec_use_vs1,
  input  logic                          dec_use_vs2,
  input  logic                          dec_wr_vd,
  input  logic                          wb_valid,
  input  logic [$clog2(NUM_VREGS)-1:0]  wb_vd,
  output logic [N_STAGES-1:0]           stall,
  output logic [N_STAGES-1:0]           flush,
  output logic                          raw_hazard,
  output logic [1:0]                    ctrl_state
`ifdef RV32V_PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]                   perf_stall_cycles,
  output logic [31:0]                   perf_raw_cycles,
  output logic [15:0]                   perf_flush_events
`endif
);

  localparam int CW = $clog2(FLUSH_HOLD + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         hold_cnt_reg, hold_cnt_next;
  logic [NUM_VREGS-1:0]  sb_reg, sb_next;
  logic [N_STAGES-1:0]   base_stall;
  logic [N_STAGES-1:0]   stall_int;
  logic [N_STAGES-1:0]   flush_int;
  logic                  hazard;
  logic                  redirect;
  logic                  issue;
  logic                  drain_done;

  // A busy stage back-pressures itself and every younger stage.
  for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_base_stall
    assign base_stall[gi] = |busy[N_STAGES-1:gi];
  end

  // Scoreboard lookup: no same-cycle writeback bypass, WAW blocks as well.
  assign hazard = dec_valid & ((dec_use_vs1 & sb_reg[dec_vs1]) |
                               (dec_use_vs2 & sb_reg[dec_vs2]) |
                               (dec_wr_vd   & sb_reg[dec_vd]));

  assign redirect   = (csr_update | exception) & (state_reg == RUN);
  assign drain_done = (state_reg == DRAIN) & ~busy[N_STAGES-1];

  // Combine base stall, hazard and drain stalls; flush always wins over stall.
  always_comb begin
    flush_int = '0;
    if (redirect || state_reg == FLUSH) begin
      flush_int[N_STAGES-2:0] = '1;
    end
    stall_int = base_stall;
    if (hazard || state_reg == DRAIN) begin
      stall_int[DEC_IDX:0] = '1;
    end
    stall_int = stall_int & ~flush_int;
  end

  assign issue = dec_valid & dec_wr_vd & ~stall_int[DEC_IDX] & ~flush_int[DEC_IDX]
               & (state_reg == RUN);

  // Outputs read as idle for as long as reset is held, whatever busy says.
  assign stall      = nRST ? stall_int : '0;
  assign flush      = nRST ? flush_int : '0;
  assign raw_hazard = nRST & hazard;
  assign ctrl_state = state_reg;

  // Next-state logic: RUN -> FLUSH (hold) -> DRAIN -> RUN; later redirects absorbed.
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      RUN: begin
        if (redirect) begin
          if (FLUSH_HOLD > 1) begin
            state_next    = FLUSH;
            hold_cnt_next = CW'(FLUSH_HOLD - 1);
          end else begin
            state_next = DRAIN;
          end
        end
      end
      FLUSH: begin
        if (hold_cnt_reg <= CW'(1)) begin
          state_next    = DRAIN;
          hold_cnt_next = '0;
        end else begin
          hold_cnt_next = hold_cnt_reg - CW'(1);
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next    = RUN;
        hold_cnt_next = '0;
      end
    endcase
  end

  // Scoreboard update: clear on writeback, set on issue (set wins), wipe at end of drain.
  always_comb begin
    sb_next = sb_reg;
    if (wb_valid) begin
      sb_next[wb_vd] = 1'b0;
    end
    if (issue) begin
      sb_next[dec_vd] = 1'b1;
    end
    if (drain_done) begin
      sb_next = '0;
    end
  end

  // State, hold counter and scoreboard registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg    <= RUN;
      hold_cnt_reg <= '0;
      sb_reg       <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      sb_reg       <= sb_next;
    end
  end

`ifdef RV32V_PIPE_CTRL_PERF_EN
  // Saturating event counters for stall cycles, hazard cycles and redirects.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_stall_cycles <= '0;
      perf_raw_cycles   <= '0;
      perf_flush_events <= '0;
    end else begin
      if (stall_int[0] && perf_stall_cycles != '1) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (hazard && perf_raw_cycles != '1) begin
        perf_raw_cycles <= perf_raw_cycles + 32'd1;
      end
      if (redirect && perf_flush_events != '1) begin
        perf_flush_events <= perf_flush_events + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/rv32v_pipe_ctrl.md
Name: rv32v_pipe_ctrl

Overview:
- Parametrised hazard and pipeline-control unit for the rv32v vector pipeline; next generation of the fixed five-stage vector hazard unit.
- Generates per-stage stall/flush vectors for any stage count.
- Adds a vector-register RAW scoreboard for decode, and a sequenced flush FSM: flush hold, then drain of the commit stage.
- Sits beside the pipeline latches; every stage latch consumes stall[i] and flush[i].

Parameters:
- N_STAGES, 5, pipeline stage count; index 0 = fetch1, N_STAGES-1 = commit (memory) stage.
- DEC_IDX, 2, index of the decode stage (0 < DEC_IDX < N_STAGES-1).
- NUM_VREGS, 32, vector registers tracked by the scoreboard.
- FLUSH_HOLD, 2, cycles flush is asserted per event (>=1).

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- busy  in  N_STAGES  busy[i] = stage i cannot advance this cycle.
- csr_update  in  1  vector CSR write committed (vsetvl etc.); redirect event.
- exception  in  1  exception raised in commit stage; redirect event.
- dec_valid  in  1  valid instruction in decode.
- dec_vs1, dec_vs2, dec_vd  in  $clog2(NUM_VREGS) each  decode register indices.
- dec_use_vs1, dec_use_vs2, dec_wr_vd  in  1 each  operand-use / destination-write flags.
- wb_valid  in  1  vector register writeback this cycle.
- wb_vd  in  $clog2(NUM_VREGS)  writeback register index.
- stall  out  N_STAGES  per-stage stall.
- flush  out  N_STAGES  per-stage flush.
- raw_hazard  out  1  decode blocked by the scoreboard.
- ctrl_state  out  2  FSM state (RUN=0, FLUSH=1, DRAIN=2).

Behaviour:
- Reset (async, nRST=0): state RUN, hold counter 0, scoreboard all 0. Outputs: stall=0, flush=0, raw_hazard=0, ctrl_state=0.
- Base stall (combinational): stall[i] = OR of busy[N_STAGES-1:i].
- raw_hazard = dec_valid & ((dec_use_vs1 & sb[dec_vs1]) | (dec_use_vs2 & sb[dec_vs2]) | (dec_wr_vd & sb[dec_vd])); WAW also blocks.
  - A wb_valid to the same register in the same cycle does not bypass: hazard persists that cycle.
  - raw_hazard ORs into stall[i] for all i <= DEC_IDX.
- Issue event = dec_valid & dec_wr_vd & ~stall[DEC_IDX] & ~flush[DEC_IDX] & state==RUN. It sets sb[dec_vd] next edge.
- wb_valid clears sb[wb_vd] next edge. If set and clear target the same index in one cycle, set wins.
- Redirect event = (csr_update | exception) while state==RUN.
- RUN:
  - Redirect asserts flush[0..N_STAGES-2] in the same cycle (zero latency); flush[N_STAGES-1] is always 0.
  - Next state: FLUSH if FLUSH_HOLD>1 (counter loads FLUSH_HOLD-1); else DRAIN.
- FLUSH:
  - flush[0..N_STAGES-2]=1 and stall[0..N_STAGES-2]=0 (flush overrides stall).
  - Counter decrements each cycle; at 1 go to DRAIN.
  - Redirect events here are absorbed, with no extension.
- DRAIN:
  - flush=0; stall[i]=1 for all i <= DEC_IDX; commit stage runs normally.
  - When busy[N_STAGES-1]==0: clear the entire scoreboard at that edge (overrides same-cycle set/clear) and go to RUN.
  - Redirect events are ignored.
- Stall/flush conflict in any state: flush wins for the flushed stages.

Optional Feature:
- Macro RV32V_PIPE_CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cycles (32), perf_raw_cycles (32), perf_flush_events (16).
  - Saturating counters, reset to 0.
  - Increment on stall[0], raw_hazard, and redirect-in-RUN respectively.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset with busy=5'b11111 held -> stall=0, flush=0, ctrl_state=0 while nRST=0; after release, stall=5'b11111.
- busy=5'b01000 (stage 3) -> stall=5'b01111; busy=5'b10000 -> stall=5'b11111.
- Issue vd=7, next cycle decode vs1=7 -> raw_hazard=1, stall[2:0]=3'b111; wb_valid wb_vd=7 -> raw_hazard=0 the cycle after writeback.
- exception pulse in RUN with FLUSH_HOLD=2 -> flush=5'b01111 for 2 cycles; then DRAIN with stall[2:0]=1 until busy[4]=0; then RUN with scoreboard all 0.
- csr_update during FLUSH and again during DRAIN -> flush not extended, state sequence unchanged.
- nRST asserted mid-FLUSH with sb[3]=1 -> immediate RUN, flush=0, sb cleared; decode vs1=3 sees no hazard.
